ahb_timer_bridge: RTL

- AHB-Lite slave front-end that sits directly upstream of the timer peripheral.
- Decodes AHB address/data phases into the timer's slave-select, write, read, size and load strobes.
- Sequences the timer's two-cycle write (load, then parity check) and one-cycle read, and returns HREADYOUT/HRESP/HRDATA.
- Generates the prescaled count-enable pulse that drives the timer when no bus transfer is active.

---
 rtl/ahb_timer_bridge.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ahb_timer_bridge.sv
// AHB-Lite slave front-end for the timer: decodes transfers into timer strobes and drives the count-enable pulse.
// Latency: write = 2 wait states + completion, read = 1 wait state, no bubble between back-to-back transfers.
// Backpressure: HREADYOUT held low while the timer reports t_done = 0; ERROR responses take two cycles.
module ahb_timer_bridge #(
    parameter int PRESCALE       = 1,
    parameter int ADDR_CHECK_MSB = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        t_en,
    output logic [31:0] t_addr,
    output logic [31:0] t_load,
    output logic        t_we,
    output logic        t_re,
    output logic [1:0]  t_size,
    input  logic [31:0] t_counter_value,
    input  logic        t_done,
    input  logic        t_check
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_LOAD, S_WR_CHECK, S_WR_EVAL, S_RD_REQ, S_RD_RESP, S_ERR1, S_ERR2
    } state_t;

    state_t         state;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [2:0]     size_q;
    logic [PW-1:0]  pre_q;

    logic           accept_ok;
    logic           xfer_vld;
    logic           illegal;
    logic           tick;
    logic [31:0]    wd_sh;
    logic [31:0]    lane_dat;
    logic           unused_htrans;

    assign unused_htrans = HTRANS[0];

    always_comb begin
        accept_ok = (state == S_IDLE) || (state == S_ERR2)
                 || ((state == S_WR_EVAL) && t_done && !t_check)
                 || ((state == S_RD_RESP) && t_done);
        xfer_vld  = accept_ok && HSEL && HREADY && HTRANS[1];
        illegal   = (HSIZE > 3'b010)
                 || ((HSIZE == 3'b001) && HADDR[0])
                 || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00))
                 || (HADDR[ADDR_CHECK_MSB:2] != '0);
        tick      = (pre_q == '0);
        // Legal halfword/word addresses have zero low bits, so one byte-granular shift serves every size.
        wd_sh     = HWDATA >> {addr_q[1:0], 3'b000};
        case (size_q)
            3'b000:  lane_dat = {24'h0, wd_sh[7:0]};
            3'b001:  lane_dat = {16'h0, wd_sh[15:0]};
            default: lane_dat = wd_sh;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        t_en      = 1'b0;
        t_we      = 1'b0;
        t_re      = 1'b0;
        t_load    = '0;
        case (state)
            // Reset gates the idle count pulse so the timer sees nothing while rst_n is low.
            S_IDLE:     t_en = tick && !xfer_vld && rst_n;
            S_WR_LOAD:  begin t_en = 1'b1; t_we = 1'b1; t_load = lane_dat; HREADYOUT = 1'b0; end
            S_WR_CHECK: begin t_en = 1'b1; t_we = 1'b1; t_load = wdata_q;  HREADYOUT = 1'b0; end
            S_WR_EVAL: begin
                if (!t_done) begin
                    HREADYOUT = 1'b0;
                end else if (t_check) begin
                    HREADYOUT = 1'b0;
                    HRESP     = 1'b1;
                end
            end
            S_RD_REQ:   begin t_en = 1'b1; t_re = 1'b1; HREADYOUT = 1'b0; end
            S_RD_RESP: begin
                if (!t_done) begin
                    HREADYOUT = 1'b0;
                end else begin
                    case (size_q)
                        3'b000:  HRDATA = {4{t_counter_value[7:0]}};
                        3'b001:  HRDATA = {2{t_counter_value[15:0]}};
                        default: HRDATA = t_counter_value;
                    endcase
                end
            end
            S_ERR1:     begin HREADYOUT = 1'b0; HRESP = 1'b1; end
            S_ERR2:     HRESP = 1'b1;
            default:    ;
        endcase
    end

    assign t_addr = addr_q;
    assign t_size = size_q[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            pre_q   <= PRE_MAX;
        end else begin
            pre_q <= tick ? PRE_MAX : pre_q - 1'b1;
            if (state == S_WR_LOAD)
                wdata_q <= lane_dat;
            if (xfer_vld) begin
                addr_q <= HADDR;
                size_q <= HSIZE;
                if (illegal)
                    state <= S_ERR1;
                else
                    state <= HWRITE ? S_WR_LOAD : S_RD_REQ;
            end else begin
                case (state)
                    S_WR_LOAD:  state <= S_WR_CHECK;
                    S_WR_CHECK: state <= S_WR_EVAL;
                    S_WR_EVAL:  if (t_done) state <= t_check ? S_ERR2 : S_IDLE;
                    S_RD_REQ:   state <= S_RD_RESP;
                    S_RD_RESP:  if (t_done) state <= S_IDLE;
                    S_ERR1:     state <= S_ERR2;
                    default:    state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
